clk_phase_seq: RTL and testbench
================================

Name: clk_phase_seq

Overview:
Parametrised successor to the core clock generator. Derives the SM83 core's nine phase clocks from one master CLK, with a programmable number of sub-phases per machine cycle. Sequences oscillator start-up and the ASYNC_RESET / SYNC_RESET release. Adds a STOP/WAKE clock-freeze mode that the fixed-phase generator lacks. Sits between board CLK/RESET and the SM83Core clock and reset pins.

Parameters:
PHASES, 8, CLK cycles per machine cycle; must be a multiple of 4 and >= 4 (Q = PHASES/4).
STABLE_CYCLES, 16, CLK cycles of oscillator settling before clocks run; >= 1.
RESET_HOLD, 4, machine cycles SYNC_RESET is held after clocks start; >= 1.
PW, $clog2(PHASES), width of PHASE.

Ports:
CLK  in  1  master clock; all logic on posedge.
RESET  in  1  synchronous, active-high reset.
STOP_REQ  in  1  level request to freeze core clocks (STOP).
WAKE  in  1  level request to resume from stopped state.
OSC_ENA  out  1  oscillator enable.
OSC_STABLE  out  1  oscillator settled.
CLK_ENA  out  1  phase clocks running.
ASYNC_RESET  out  1  core asynchronous reset.
SYNC_RESET  out  1  core synchronous reset.
PHASE  out  PW  current sub-phase 0..PHASES-1.
MCYCLE_STB  out  1  high on last phase of a running machine cycle.
ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N, INC_CLK_P, INC_CLK_N, MAIN_CLK_P, MAIN_CLK_N, LATCH_CLK  out  1 each  core phase clocks.

Behaviour:
- All outputs registered. No combinational path from inputs to outputs.
- Reset (RESET=1 at an edge, in any state, including mid-cycle or while stopped):
  - State goes to OFF.
  - OSC_ENA=0, OSC_STABLE=0, CLK_ENA=0, ASYNC_RESET=1, SYNC_RESET=1, PHASE=0, MCYCLE_STB=0.
  - Clocks go idle: all _P=0, all _N=1, LATCH_CLK=0.
- States: OFF, START, RESETTING, RUN, STOPPED.
- OFF -> START on the first edge with RESET=0. That edge sets OSC_ENA=1 and clears the settle counter.
- START: the settle counter increments each edge. On the STABLE_CYCLES-th edge in START (edge 1+STABLE_CYCLES after reset release), go to RESETTING and in that same edge:
  - set OSC_STABLE=1, CLK_ENA=1;
  - clear ASYNC_RESET to 0;
  - set PHASE=0.
- RESETTING: PHASE runs and SYNC_RESET stays 1. Leave on the edge that ends the RESET_HOLD-th machine cycle (PHASE wraps to 0): go to RUN and clear SYNC_RESET to 0 in the same edge.
- RUN: PHASE increments modulo PHASES each edge.
  - STOP_REQ is sampled only when PHASE==PHASES-1. If it is 1, the wrap edge enters STOPPED with PHASE=0, CLK_ENA=0 and clocks idle.
  - STOP_REQ at other phases has no effect.
  - WAKE is ignored in RUN.
- STOPPED: PHASE is held at 0, clocks idle; OSC_ENA and OSC_STABLE stay 1.
  - WAKE=1 at an edge -> RUN with CLK_ENA=1, PHASE=0.
  - WAKE has priority over a simultaneous STOP_REQ.
- Clock decode, when CLK_ENA=1, is a function of the PHASE value visible in the same cycle:
  - ADR_CLK_P = PHASE < 2Q.
  - DATA_CLK_P = Q <= PHASE < 3Q.
  - INC_CLK_P = PHASE >= 2Q.
  - MAIN_CLK_P = (PHASE >= 3Q) or (PHASE < Q).
  - LATCH_CLK = (PHASE == PHASES-1).
  - Each _N is the exact complement of its _P.
- Clock idle levels apply whenever CLK_ENA=0.
- MCYCLE_STB = CLK_ENA and PHASE==PHASES-1. It therefore equals LATCH_CLK while running.
- Parameter violations are caught by an elaboration-time check that stops simulation ($fatal) when PHASES%4 != 0, PHASES < 4, STABLE_CYCLES < 1 or RESET_HOLD < 1.

Test Plan:
1. Defaults; RESET high for 8 edges, then low.
   -> OSC_ENA=1 at edge 1.
   -> OSC_STABLE=1, CLK_ENA=1, ASYNC_RESET=0 at edge 17.
   -> SYNC_RESET=0 at edge 49 (17+4*8), PHASE=0.
2. RUN, defaults; check the decode over PHASE 0..7.
   -> ADR_P=11110000, DATA_P=00111100, INC_P=00001111, MAIN_P=11000011, LATCH=00000001; every _N is the complement.
3. STOP_REQ=1 from PHASE 3 through PHASE 7.
   -> Nothing changes until the PHASE 7 edge, then STOPPED: PHASE=0, CLK_ENA=0, _P=0, _N=1, OSC_STABLE stays 1.
   -> Then WAKE=1 for one cycle -> next edge CLK_ENA=1, PHASE=0, and PHASE=1 on the following edge.
4. STOPPED with STOP_REQ=1 and WAKE=1 together -> RUN next edge, not re-stopped until the next PHASE 7 sample.
5. RESET pulse at PHASE 5 in RUN -> next edge gives all reset values; the full start-up sequence of scenario 1 repeats with identical edge counts.
6. PHASES=16, STABLE_CYCLES=3, RESET_HOLD=2.
   -> OSC_STABLE at edge 4, SYNC_RESET low at edge 36.
   -> ADR_P high for PHASE 0..7, DATA_P for 4..11, MAIN_P for 12..15 and 0..3, LATCH only at PHASE 15.

Source files
------------

// File: rtl/clk_phase_seq.sv
// SM83 phase-clock generator: oscillator start-up, reset release sequencing,
// programmable sub-phases per machine cycle and STOP/WAKE clock freeze.
module clk_phase_seq #(
  parameter int PHASES        = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int RESET_HOLD    = 4,
  parameter int PW            = $clog2(PHASES)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STOP_REQ,
  input  logic          WAKE,
  output logic          OSC_ENA,
  output logic          OSC_STABLE,
  output logic          CLK_ENA,
  output logic          ASYNC_RESET,
  output logic          SYNC_RESET,
  output logic [PW-1:0] PHASE,
  output logic          MCYCLE_STB,
  output logic          ADR_CLK_P,
  output logic          ADR_CLK_N,
  output logic          DATA_CLK_P,
  output logic          DATA_CLK_N,
  output logic          INC_CLK_P,
  output logic          INC_CLK_N,
  output logic          MAIN_CLK_P,
  output logic          MAIN_CLK_N,
  output logic          LATCH_CLK
);

  if ((PHASES % 4) != 0 || PHASES < 4 || STABLE_CYCLES < 1 || RESET_HOLD < 1) begin : g_param_check
    $fatal(1, "clk_phase_seq: illegal parameter set");
  end

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [PW-1:0] Q1   = PW'(PHASES / 4);
  localparam logic [PW-1:0] Q2   = PW'(PHASES / 2);
  localparam logic [PW-1:0] Q3   = PW'((3 * PHASES) / 4);
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  typedef enum logic [2:0] {OFF, START, RESETTING, RUN, STOPPED} state_t;

  state_t        state_q, state_n;
  logic [SW-1:0] settle_q, settle_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [PW-1:0] phase_n, phase_inc;
  logic          wrap;
  logic          osc_ena_n, osc_stable_n, clk_ena_n, async_n, sync_n;
  logic          adr_n, data_n, inc_n, main_n, latch_n;

  always_comb begin
    state_n      = state_q;
    settle_n     = settle_q;
    hold_n       = hold_q;
    phase_n      = PHASE;
    osc_ena_n    = OSC_ENA;
    osc_stable_n = OSC_STABLE;
    clk_ena_n    = CLK_ENA;
    async_n      = ASYNC_RESET;
    sync_n       = SYNC_RESET;
    wrap         = (PHASE == LAST);
    phase_inc    = wrap ? '0 : PHASE + PW'(1);

    unique case (state_q)
      OFF: begin
        state_n   = START;
        osc_ena_n = 1'b1;
        settle_n  = '0;
      end
      START: begin
        settle_n = settle_q + SW'(1);
        if (settle_n == SW'(STABLE_CYCLES)) begin
          state_n      = RESETTING;
          osc_stable_n = 1'b1;
          clk_ena_n    = 1'b1;
          async_n      = 1'b0;
          phase_n      = '0;
          hold_n       = '0;
        end
      end
      RESETTING: begin
        phase_n = phase_inc;
        if (wrap) begin
          if (hold_q == HW'(RESET_HOLD - 1)) begin
            state_n = RUN;
            sync_n  = 1'b0;
          end else begin
            hold_n = hold_q + HW'(1);
          end
        end
      end
      RUN: begin
        phase_n = phase_inc;
        if (wrap && STOP_REQ) begin
          state_n   = STOPPED;
          clk_ena_n = 1'b0;
        end
      end
      STOPPED: begin
        phase_n = '0;
        if (WAKE) begin
          state_n   = RUN;
          clk_ena_n = 1'b1;
        end
      end
      default: state_n = OFF;
    endcase

    // Decode from the next-cycle phase so the registered clocks line up with PHASE.
    adr_n   = clk_ena_n && (phase_n < Q2);
    data_n  = clk_ena_n && (phase_n >= Q1) && (phase_n < Q3);
    inc_n   = clk_ena_n && (phase_n >= Q2);
    main_n  = clk_ena_n && ((phase_n >= Q3) || (phase_n < Q1));
    latch_n = clk_ena_n && (phase_n == LAST);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= OFF;
      settle_q    <= '0;
      hold_q      <= '0;
      OSC_ENA     <= 1'b0;
      OSC_STABLE  <= 1'b0;
      CLK_ENA     <= 1'b0;
      ASYNC_RESET <= 1'b1;
      SYNC_RESET  <= 1'b1;
      PHASE       <= '0;
      MCYCLE_STB  <= 1'b0;
      ADR_CLK_P   <= 1'b0;
      ADR_CLK_N   <= 1'b1;
      DATA_CLK_P  <= 1'b0;
      DATA_CLK_N  <= 1'b1;
      INC_CLK_P   <= 1'b0;
      INC_CLK_N   <= 1'b1;
      MAIN_CLK_P  <= 1'b0;
      MAIN_CLK_N  <= 1'b1;
      LATCH_CLK   <= 1'b0;
    end else begin
      state_q     <= state_n;
      settle_q    <= settle_n;
      hold_q      <= hold_n;
      OSC_ENA     <= osc_ena_n;
      OSC_STABLE  <= osc_stable_n;
      CLK_ENA     <= clk_ena_n;
      ASYNC_RESET <= async_n;
      SYNC_RESET  <= sync_n;
      PHASE       <= phase_n;
      MCYCLE_STB  <= latch_n;
      ADR_CLK_P   <= adr_n;
      ADR_CLK_N   <= ~adr_n;
      DATA_CLK_P  <= data_n;
      DATA_CLK_N  <= ~data_n;
      INC_CLK_P   <= inc_n;
      INC_CLK_N   <= ~inc_n;
      MAIN_CLK_P  <= main_n;
      MAIN_CLK_N  <= ~main_n;
      LATCH_CLK   <= latch_n;
    end
  end

endmodule

// File: tb/tb_clk_phase_seq.sv
// Directed bench for clk_phase_seq: default instance plus a PHASES=16 instance.
module tb_clk_phase_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, stop_req = 1'b0, wake = 1'b0, stop16 = 1'b0, wake16 = 1'b0;

  logic osc_ena, osc_stable, clk_ena, async_rst, sync_rst, mstb;
  logic adr_p, adr_n, data_p, data_n, inc_p, inc_n, main_p, main_n, latch;
  logic [2:0] phase;

  logic osc_ena16, osc_stable16, clk_ena16, async16, sync16, mstb16;
  logic adr_p16, adr_n16, data_p16, data_n16, inc_p16, inc_n16, main_p16, main_n16, latch16;
  logic [3:0] phase16;

  clk_phase_seq dut (
    .CLK(clk), .RESET(rst), .STOP_REQ(stop_req), .WAKE(wake),
    .OSC_ENA(osc_ena), .OSC_STABLE(osc_stable), .CLK_ENA(clk_ena),
    .ASYNC_RESET(async_rst), .SYNC_RESET(sync_rst), .PHASE(phase), .MCYCLE_STB(mstb),
    .ADR_CLK_P(adr_p), .ADR_CLK_N(adr_n), .DATA_CLK_P(data_p), .DATA_CLK_N(data_n),
    .INC_CLK_P(inc_p), .INC_CLK_N(inc_n), .MAIN_CLK_P(main_p), .MAIN_CLK_N(main_n),
    .LATCH_CLK(latch)
  );

  clk_phase_seq #(.PHASES(16), .STABLE_CYCLES(3), .RESET_HOLD(2)) dut16 (
    .CLK(clk), .RESET(rst), .STOP_REQ(stop16), .WAKE(wake16),
    .OSC_ENA(osc_ena16), .OSC_STABLE(osc_stable16), .CLK_ENA(clk_ena16),
    .ASYNC_RESET(async16), .SYNC_RESET(sync16), .PHASE(phase16), .MCYCLE_STB(mstb16),
    .ADR_CLK_P(adr_p16), .ADR_CLK_N(adr_n16), .DATA_CLK_P(data_p16), .DATA_CLK_N(data_n16),
    .INC_CLK_P(inc_p16), .INC_CLK_N(inc_n16), .MAIN_CLK_P(main_p16), .MAIN_CLK_N(main_n16),
    .LATCH_CLK(latch16)
  );

  int checks = 0;
  int errors = 0;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ADR_P, ADR_N, DATA_P, DATA_N, INC_P, INC_N, MAIN_P, MAIN_N, LATCH}
  function automatic logic [8:0] cvec(input logic a, input logic d, input logic i,
                                      input logic m, input logic l);
    return {a, ~a, d, ~d, i, ~i, m, ~m, l};
  endfunction

  localparam logic [8:0] IDLE = 9'b010101010;

  function automatic logic [8:0] clocks();
    return {adr_p, adr_n, data_p, data_n, inc_p, inc_n, main_p, main_n, latch};
  endfunction

  function automatic logic [8:0] clocks16();
    return {adr_p16, adr_n16, data_p16, data_n16, inc_p16, inc_n16, main_p16, main_n16, latch16};
  endfunction

  task automatic chk_reset_state();
    chk("rst_ctl", {26'd0, osc_ena, osc_stable, clk_ena, async_rst, sync_rst, mstb}, 32'b000110);
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_clocks", {23'd0, clocks()}, {23'd0, IDLE});
    chk("rst_ctl16", {26'd0, osc_ena16, osc_stable16, clk_ena16, async16, sync16, mstb16}, 32'b000110);
  endtask

  // Release reset and walk edges 1..49 checking the start-up milestones of both instances.
  task automatic startup();
    rst = 1'b0;
    for (int e = 1; e <= 49; e++) begin
      step();
      if (e == 1)  chk("e1_osc_ena", {31'd0, osc_ena}, 32'd1);
      if (e == 1)  chk("e1_stable", {31'd0, osc_stable}, 32'd0);
      if (e == 16) chk("e16_stable_clk", {30'd0, osc_stable, clk_ena}, 32'b00);
      if (e == 17) chk("e17_ctl", {27'd0, osc_stable, clk_ena, async_rst, sync_rst, osc_ena}, 32'b11011);
      if (e == 17) chk("e17_phase", {29'd0, phase}, 32'd0);
      if (e == 48) chk("e48_sync_phase", {28'd0, sync_rst, phase}, {28'd0, 1'b1, 3'd7});
      if (e == 49) chk("e49_sync_phase", {28'd0, sync_rst, phase}, 32'd0);
      if (e == 3)  chk("d16_e3_stable", {31'd0, osc_stable16}, 32'd0);
      if (e == 4)  chk("d16_e4_ctl", {29'd0, osc_stable16, clk_ena16, async16}, 32'b110);
      if (e == 35) chk("d16_e35_sync", {31'd0, sync16}, 32'd1);
      if (e == 36) chk("d16_e36_sync_phase", {27'd0, sync16, phase16}, 32'd0);
    end
  endtask

  logic [7:0] adr_t, data_t, inc_t, main_t, latch_t;

  initial begin
    adr_t = 8'b11110000; data_t = 8'b00111100; inc_t = 8'b00001111;
    main_t = 8'b11000011; latch_t = 8'b00000001;

    // Scenario 1: long reset then start-up
    step(8);
    chk_reset_state();
    startup();

    // Scenario 2: decode over one machine cycle
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("dec_phase%0d", p), {29'd0, phase}, p);
      chk($sformatf("dec_clocks%0d", p), {23'd0, clocks()},
          {23'd0, cvec(adr_t[7-p], data_t[7-p], inc_t[7-p], main_t[7-p], latch_t[7-p])});
      chk($sformatf("dec_mstb%0d", p), {31'd0, mstb}, {31'd0, latch_t[7-p]});
      step();
    end

    // Scenario 3: STOP_REQ from phase 3, honoured only on the phase-7 edge
    step(3);
    chk("s3_phase3", {29'd0, phase}, 32'd3);
    stop_req = 1'b1;
    for (int p = 4; p < 8; p++) begin
      step();
      chk($sformatf("s3_run_p%0d", p), {28'd0, clk_ena, phase}, {28'd0, 1'b1, 3'(p)});
    end
    step();
    chk("s3_stopped", {26'd0, clk_ena, phase, osc_ena, osc_stable}, {26'd0, 1'b0, 3'd0, 2'b11});
    chk("s3_stop_clocks", {23'd0, clocks()}, {23'd0, IDLE});
    chk("s3_stop_mstb", {31'd0, mstb}, 32'd0);
    stop_req = 1'b0;
    step(2);
    chk("s3_still_stopped", {28'd0, clk_ena, phase}, 32'd0);
    wake = 1'b1;
    step();
    wake = 1'b0;
    chk("s3_wake", {28'd0, clk_ena, phase}, {28'd0, 1'b1, 3'd0});
    chk("s3_wake_clocks", {23'd0, clocks()}, {23'd0, cvec(1, 0, 0, 1, 0)});
    step();
    chk("s3_wake_p1", {28'd0, clk_ena, phase}, {28'd0, 1'b1, 3'd1});

    // Scenario 4: WAKE beats a simultaneous STOP_REQ
    step(6);
    stop_req = 1'b1;
    step();
    chk("s4_stopped", {31'd0, clk_ena}, 32'd0);
    wake = 1'b1;
    step();
    wake = 1'b0;
    chk("s4_wake_prio", {28'd0, clk_ena, phase}, {28'd0, 1'b1, 3'd0});
    step(7);
    chk("s4_p7_running", {28'd0, clk_ena, phase}, {28'd0, 1'b1, 3'd7});
    step();
    chk("s4_restopped", {28'd0, clk_ena, phase}, 32'd0);
    stop_req = 1'b0;
    wake = 1'b1;
    step();
    wake = 1'b0;
    step(5);
    chk("s4_p5", {28'd0, clk_ena, phase}, {28'd0, 1'b1, 3'd5});

    // Scenario 5: reset pulse mid-cycle, then identical start-up
    rst = 1'b1;
    step();
    chk_reset_state();
    startup();

    // Scenario 6: PHASES=16 decode (phase16 is 13 at edge 49)
    step(3);
    for (int p = 0; p < 16; p++) begin
      chk($sformatf("d16_phase%0d", p), {28'd0, phase16}, p);
      chk($sformatf("d16_clocks%0d", p), {23'd0, clocks16()},
          {23'd0, cvec(p < 8, p >= 4 && p < 12, p >= 8, p >= 12 || p < 4, p == 15)});
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
